// File: rtl/rgb_led_scheduler.sv
// rtl/rgb_led_scheduler.sv - round-robin time-slot scheduler sharing one RGB status LED
module rgb_led_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] SLOT_CYCLES = 32'd27_000_000,
  parameter logic [31:0] GAP_CYCLES  = 32'd2_700_000,
  parameter logic [23:0] IDLE_RGB    = 24'h000000
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [24*NUM_REQ-1:0] req_rgb,
  input  logic [NUM_REQ-1:0]    req_blink,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [23:0]           rgb,
  output logic                  blink_en,
  output logic                  busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          any_req;
  logic [31:0]   cnt;
  int            j;

  // Round-robin search starting just after the last winner; walking from the
  // farthest candidate to the nearest lets the nearest active one win.
  always_comb begin
    win     = ptr;
    cand    = ptr;
    any_req = 1'b0;
    j       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j    = (int'(ptr) + k) % NUM_REQ;
      cand = j[PW-1:0];
      if (req[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
    end
  end

  // Slot sequencer: arbitrate in IDLE, display a snapshot in SHOW, stay dark in GAP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      ptr      <= PW'(NUM_REQ - 1);
      cnt      <= '0;
      grant    <= '0;
      done     <= '0;
      rgb      <= IDLE_RGB;
      blink_en <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= SHOW;
            ptr      <= win;
            grant    <= ONE << win;
            rgb      <= req_rgb[24*win +: 24];
            blink_en <= req_blink[win];
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end
        SHOW: begin
          cnt <= cnt + 32'd1;
          // A dropped request aborts the slot; done only fires if it is still held.
          if (!req[ptr] || cnt == SLOT_CYCLES - 32'd1) begin
            grant    <= '0;
            rgb      <= IDLE_RGB;
            blink_en <= 1'b0;
            cnt      <= '0;
            if (req[ptr]) done[ptr] <= 1'b1;
            if (GAP_CYCLES == 32'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (cnt == GAP_CYCLES - 32'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rgb_led_scheduler.md
# rgb_led_scheduler

Time-slot scheduler that shares one RGB status LED among several requesters. It round-robins among the active requests and shows each winner's colour and blink mode for a fixed slot. Between slots it holds the LED dark for a short gap. It sits directly upstream of the PWM RGB LED driver and supplies that driver's `rgb` and `blink_en` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `SLOT_CYCLES`, 32'd27_000_000: cycles a granted request is displayed (1.0 s at 27 MHz); must be ≥ 1.
- `GAP_CYCLES`, 32'd2_700_000: dark cycles after each slot or abort (0.1 s); 0 = no gap.
- `IDLE_RGB`, 24'h000000: colour driven when no slot is active.

Ports:
- `clk`  in  1  system clock, 27 MHz nominal
- `n_rst`  in  1  reset, asynchronous, active-low
- `req`  in  NUM_REQ  level request per requester
- `req_rgb`  in  24*NUM_REQ  colour per requester; requester i uses bits [24*i+23 : 24*i]
- `req_blink`  in  NUM_REQ  blink request per requester
- `grant`  out  NUM_REQ  one-hot; high while that requester's slot is displayed
- `done`  out  NUM_REQ  one-cycle pulse when a slot completes normally
- `rgb`  out  24  colour to LED driver
- `blink_en`  out  1  blink enable to LED driver
- `busy`  out  1  high in SHOW or GAP

## Operation
- States: IDLE, SHOW, GAP.
- IDLE:
  - `rgb`=IDLE_RGB, `blink_en`=0, `grant`=0.
  - If any `req` bit is high, pick the winner by round-robin, searching from `ptr`+1 modulo NUM_REQ.
  - Latch the winner's `req_rgb` slice and `req_blink` bit, set `grant[w]`, set `ptr`=w, clear the slot counter, go to SHOW.
- SHOW:
  - `rgb` and `blink_en` hold the latched snapshot. Later changes on `req_rgb` and `req_blink` are ignored until the next grant.
  - The slot counter increments every cycle.
  - On the last slot cycle (counter = SLOT_CYCLES-1) with `req[w]` still high: next cycle drop `grant`, pulse `done[w]`, enter GAP.
  - If `req[w]` is low in any SHOW cycle (abort): next cycle drop `grant`, no `done`, enter GAP. Abort takes precedence over completion in the same cycle.
- GAP:
  - `rgb`=IDLE_RGB, `blink_en`=0; lasts exactly GAP_CYCLES cycles, then IDLE.
  - With GAP_CYCLES=0, skip GAP and go straight from SHOW to IDLE.
  - Requests are not arbitrated during GAP.
- A requester that keeps `req` high after `done` is re-queued. It is served again only after the other pending requesters, per round-robin.
- Reset values:
  - State IDLE, `ptr`=NUM_REQ-1 (so requester 0 wins the first tie).
  - Counters 0, `grant`=0, `done`=0, `rgb`=IDLE_RGB, `blink_en`=0, `busy`=0.
- Asserting `n_rst` mid-slot clears everything immediately. No `done` is issued for the interrupted slot.
- Counters are 32-bit and compared for equality only, so there is no wrap-around inside valid parameter ranges.

## Timing
- All outputs are registered.
- `req` sampled high in IDLE at cycle N → `grant`, `rgb`, `blink_en`, `busy` updated at N+1.
- `grant[w]` is high for exactly SLOT_CYCLES cycles on normal completion.
- `done[w]` is high for exactly one cycle, the first cycle with `grant[w]` low.
- Earliest next grant: done cycle + GAP_CYCLES + 1. The +1 is the IDLE arbitration cycle.
- Abort: `req[w]` low at cycle M → `grant` low at M+1.
- Simultaneous `req` bits are resolved in the same single IDLE cycle; exactly one grant is issued.

## Test plan
Parameters for all scenarios: NUM_REQ=4, SLOT_CYCLES=10, GAP_CYCLES=3, IDLE_RGB=0.
- **Single request:** after reset, `req`=4'b0010 with colour 24'hFF8000, blink=1.
  - `grant`=0010 one cycle later, for 10 cycles.
  - `rgb`=FF8000 and `blink_en`=1 throughout.
  - `done[1]` pulses once, then 3 dark cycles with `busy`=1.
- **Round-robin:** `req`=4'b1111 held continuously → grant order 0,1,2,3,0.
  - Each slot is 10 cycles.
  - Consecutive grants are 14 cycles apart (slot end to next grant: 3 gap + 1 IDLE).
- **Snapshot:** change `req_rgb` slice 0 from 00FF00 to 0000FF mid-slot → `rgb` stays 00FF00 until that slot ends.
- **Abort:** drop `req[2]` at slot cycle 4.
  - `grant` clears next cycle, no `done`.
  - 3 gap cycles follow, then the next pending requester is served.
- **Zero gap:** GAP_CYCLES=0 with `req`=4'b0011 → grant 0 then grant 1, with `grant`=0 for exactly one cycle between them.
- **Reset mid-slot:** pulse `n_rst` low during SHOW.
  - All outputs return to reset values asynchronously, with no `done` pulse.
  - The next grant goes to requester 0 first.
